// File: rtl/m_dmem_resp_pkg.sv
// Shared definitions for the multi-cycle data-memory responder: FSM encoding,
// the tohost mailbox address and the wait-state limit.
package m_dmem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] TOHOST_ADDR  = 32'hFFFF_FFF0;
    localparam int unsigned WAIT_CYC_MAX = 15;

    // Out-of-range settings saturate instead of silently wrapping the 4-bit counter.
    function automatic logic [3:0] wait_load(input int unsigned cyc);
        return (cyc > WAIT_CYC_MAX) ? 4'(WAIT_CYC_MAX) : 4'(cyc);
    endfunction

endpackage

// File: rtl/m_dmem_ram.sv
// Synchronous single-port word RAM with per-byte write enables and a
// registered read port.
module m_dmem_ram #(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic [3:0]        be_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem [0:(1 << ADDR_W)-1];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            if (be_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        rdata_o <= mem[addr_i];
    end

endmodule

// File: rtl/m_dmem_resp.sv
// Multi-cycle data-memory responder: req/ack handshake, programmable wait states,
// byte-enabled RAM access. Optional tohost mailbox under DMEM_RESP_TOHOST_EN.
module m_dmem_resp
    import m_dmem_resp_pkg::*;
#(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned WAIT_CYC = 2,
    parameter logic [31:0] MEM_BASE = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_req,
    input  logic        w_we,
    input  logic [31:0] w_addr,
    input  logic [3:0]  w_be,
    input  logic [31:0] w_wdata,
    output logic        w_ack,
    output logic [31:0] w_rdata,
    output logic        w_err,
    output logic        w_busy
`ifdef DMEM_RESP_TOHOST_EN
    ,
    output logic [31:0] w_tohost,
    output logic        w_halt
`endif
);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    logic        accept;
    logic [31:0] offset;
    logic        inRange;
    logic        isTohost;
    logic [31:0] selAddr;
    logic [31:0] selOff;
    logic [3:0]  ramBe;
    logic [31:0] ramRdata;
    logic        unusedBits;

    assign accept = (state_q == IDLE) && w_req;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (w_req) begin
                    cnt_d   = wait_load(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= w_we;
                addr_q  <= w_addr;
                be_q    <= w_be;
                wdata_q <= w_wdata;
            end
        end
    end

    // Full-width compare so addresses below the base or past the top never wrap into the RAM.
    assign offset  = addr_q - MEM_BASE;
    assign inRange = (addr_q >= MEM_BASE) &&
                     ({3'b000, offset[31:2]} < (33'd1 << ADDR_W));

    // The live address feeds the RAM in IDLE so a zero-wait read is ready in the RESP cycle.
    assign selAddr    = (state_q == IDLE) ? w_addr : addr_q;
    assign selOff     = selAddr - MEM_BASE;
    assign unusedBits = ^{selOff[31:ADDR_W+2], selOff[1:0], offset[1:0]};
    assign ramBe      = ((state_q == RESP) && we_q && inRange && !isTohost) ? be_q : 4'b0000;

    m_dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (w_clk),
        .be_i    (ramBe),
        .addr_i  (selOff[ADDR_W+1:2]),
        .wdata_i (wdata_q),
        .rdata_o (ramRdata)
    );

`ifdef DMEM_RESP_TOHOST_EN
    logic [31:0] tohost_q;
    logic        halt_q;

    assign isTohost = ({addr_q[31:2], 2'b00} == TOHOST_ADDR);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            tohost_q <= '0;
            halt_q   <= 1'b0;
        end else if ((state_q == RESP) && we_q && isTohost) begin
            tohost_q <= wdata_q;
            halt_q   <= 1'b1;
        end
    end

    assign w_tohost = tohost_q;
    assign w_halt   = halt_q;
`else
    assign isTohost = 1'b0;
`endif

    assign w_ack  = (state_q == RESP);
    assign w_busy = (state_q != IDLE);

    always_comb begin
        w_rdata = '0;
        w_err   = 1'b0;
        if (state_q == RESP) begin
`ifdef DMEM_RESP_TOHOST_EN
            if (isTohost) begin
                if (!we_q) begin
                    w_rdata = tohost_q;
                end
            end else
`endif
            if (!inRange) begin
                w_err = 1'b1;
            end else if (!we_q) begin
                w_rdata = ramRdata;
            end
        end
    end

endmodule
